// File: rtl/snake_head_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snake_head_ctrl
// Purpose  : Snake head-motion engine: button sync, reversal filter, speed
//            tick and grid stepping. Define SNAKE_WRAP_EN for wrapping walls.
// Revision : 1.0 - initial release
// ============================================================================
module snake_head_ctrl #(
    parameter int GRID_W     = 32,
    parameter int GRID_H     = 24,
    parameter int X_W        = 5,
    parameter int Y_W        = 5,
    parameter int TICK_DIV   = 50000,
    parameter int SPEED_LVLS = 8,
    parameter int SPEED_W    = 3,
    parameter int START_X    = 16,
    parameter int START_Y    = 12
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [3:0]         i_Push,
    input  logic               i_Pause,
    input  logic [SPEED_W-1:0] i_Speed,
    input  logic               i_Restart,
    output logic [X_W-1:0]     o_HeadX,
    output logic [Y_W-1:0]     o_HeadY,
    output logic [1:0]         o_Dir,
    output logic               o_Step,
    output logic               o_Dead,
    output logic [1:0]         o_State
);

    localparam int TMR_W = $clog2(TICK_DIV * SPEED_LVLS + 1);

    localparam logic [X_W-1:0]   X_MAX      = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]   Y_MAX      = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0]   X_START    = X_W'(START_X);
    localparam logic [Y_W-1:0]   Y_START    = Y_W'(START_Y);
    localparam logic [TMR_W-1:0] PERIOD_RST = TMR_W'(TICK_DIV * SPEED_LVLS);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

`ifdef SNAKE_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         sync1_q, sync1_d;
    logic [3:0]         sync2_q, sync2_d;
    logic [3:0]         prev_q, prev_d;
    logic [1:0]         dir_q, dir_d;
    logic [1:0]         pend_q, pend_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic               step_q, step_d;
    logic               dead_q, dead_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [TMR_W-1:0]   period_q, period_d;

    logic [3:0]         press;
    logic               press_any;
    logic [1:0]         press_dir;
    logic               reversal;
    logic [31:0]        spd_ext;
    logic [31:0]        spd_clamp;
    logic [TMR_W-1:0]   period_new;
    logic [X_W-1:0]     nx;
    logic [Y_W-1:0]     ny;
    logic               hit_wall;
    logic               period_end;

    // Buttons are active-low, so a press is a falling edge after the synchroniser.
    assign press     = prev_q & ~sync2_q;
    assign press_any = |press;

    always_comb begin
        press_dir = DIR_RIGHT;
        if (press[0])      press_dir = DIR_UP;
        else if (press[1]) press_dir = DIR_DOWN;
        else if (press[2]) press_dir = DIR_LEFT;
        else               press_dir = DIR_RIGHT;
    end

    // Same axis (bit 1) but different direction means a 180-degree turn.
    assign reversal = (press_dir[1] == dir_q[1]) && (press_dir != dir_q);

    always_comb begin
        spd_ext    = 32'(i_Speed);
        spd_clamp  = (spd_ext > 32'(SPEED_LVLS - 1)) ? 32'(SPEED_LVLS - 1) : spd_ext;
        period_new = TMR_W'(32'(TICK_DIV) * (32'(SPEED_LVLS) - spd_clamp));
    end

    assign period_end = (timer_q == (period_q - TMR_W'(1)));

    always_comb begin
        nx       = x_q;
        ny       = y_q;
        hit_wall = 1'b0;
        case (pend_q)
            DIR_UP: begin
                if (y_q == '0) begin
                    ny       = Y_MAX;
                    hit_wall = 1'b1;
                end else begin
                    ny = y_q - Y_W'(1);
                end
            end
            DIR_DOWN: begin
                if (y_q == Y_MAX) begin
                    ny       = '0;
                    hit_wall = 1'b1;
                end else begin
                    ny = y_q + Y_W'(1);
                end
            end
            DIR_LEFT: begin
                if (x_q == '0) begin
                    nx       = X_MAX;
                    hit_wall = 1'b1;
                end else begin
                    nx = x_q - X_W'(1);
                end
            end
            default: begin
                if (x_q == X_MAX) begin
                    nx       = '0;
                    hit_wall = 1'b1;
                end else begin
                    nx = x_q + X_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        sync1_d  = i_Push;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        dir_d    = dir_q;
        pend_d   = pend_q;
        x_d      = x_q;
        y_d      = y_q;
        step_d   = 1'b0;
        dead_d   = dead_q;
        timer_d  = timer_q;
        period_d = period_q;

        if (i_Restart) begin
            state_d = ST_IDLE;
            dir_d   = DIR_RIGHT;
            pend_d  = DIR_RIGHT;
            x_d     = X_START;
            y_d     = Y_START;
            dead_d  = 1'b0;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timer_d  = '0;
                    period_d = period_new;
                    if (press_any) begin
                        dir_d   = press_dir;
                        pend_d  = press_dir;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_Pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        if (period_end) begin
                            timer_d  = '0;
                            period_d = period_new;
                            dir_d    = pend_q;
                            if (hit_wall && !WRAP) begin
                                dead_d  = 1'b1;
                                state_d = ST_DEAD;
                            end else begin
                                x_d    = nx;
                                y_d    = ny;
                                step_d = 1'b1;
                            end
                        end else begin
                            timer_d = timer_q + TMR_W'(1);
                        end
                        // Compared against the current heading, so it only steers the next step.
                        if (press_any && !reversal) begin
                            pend_d = press_dir;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!i_Pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_DEAD;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= ST_IDLE;
            sync1_q  <= 4'hF;
            sync2_q  <= 4'hF;
            prev_q   <= 4'hF;
            dir_q    <= DIR_RIGHT;
            pend_q   <= DIR_RIGHT;
            x_q      <= X_START;
            y_q      <= Y_START;
            step_q   <= 1'b0;
            dead_q   <= 1'b0;
            timer_q  <= '0;
            period_q <= PERIOD_RST;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            x_q      <= x_d;
            y_q      <= y_d;
            step_q   <= step_d;
            dead_q   <= dead_d;
            timer_q  <= timer_d;
            period_q <= period_d;
        end
    end

    assign o_HeadX = x_q;
    assign o_HeadY = y_q;
    assign o_Dir   = dir_q;
    assign o_Step  = step_q;
    assign o_Dead  = dead_q;
    assign o_State = state_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_head_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_head_ctrl
// Purpose  : Scoreboard bench for snake_head_ctrl (TICK_DIV=4, SPEED_LVLS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_head_ctrl;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [3:0] i_Push = 4'hF;
    logic       i_Pause = 1'b0;
    logic [2:0] i_Speed = 3'd3;
    logic       i_Restart = 1'b0;
    logic [4:0] o_HeadX;
    logic [4:0] o_HeadY;
    logic [1:0] o_Dir;
    logic       o_Step;
    logic       o_Dead;
    logic [1:0] o_State;

    snake_head_ctrl #(
        .TICK_DIV   (4),
        .SPEED_LVLS (4)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .i_Push    (i_Push),
        .i_Pause   (i_Pause),
        .i_Speed   (i_Speed),
        .i_Restart (i_Restart),
        .o_HeadX   (o_HeadX),
        .o_HeadY   (o_HeadY),
        .o_Dir     (o_Dir),
        .o_Step    (o_Step),
        .o_Dead    (o_Dead),
        .o_State   (o_State)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
        logic [1:0] dir;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push(input int x, input int y, input int d);
        exp_t t;
        t.x   = 5'(x);
        t.y   = 5'(y);
        t.dir = 2'(d);
        sb.push_back(t);
    endtask

    task automatic press(input logic [3:0] p);
        i_Push = p;
        repeat (3) tick();
        i_Push = 4'hF;
    endtask

    task automatic wait_step(input string name, input int exp_n);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            n++;
            if (o_Step) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk({name, "_timeout"}, 0, 1);
        else       chk(name, n, exp_n);
    endtask

    // Monitor: every step pulse must match the oldest expected head move.
    always @(posedge Clk) begin
        #1;
        if (o_Step) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL step_unexpected: got step to X=%0d Y=%0d, required no step",
                         o_HeadX, o_HeadY);
            end else begin
                e = sb.pop_front();
                if (o_HeadX != e.x || o_HeadY != e.y || o_Dir != e.dir) begin
                    errors++;
                    $display("FAIL step_pos: got X=%0d Y=%0d D=%0d, required X=%0d Y=%0d D=%0d",
                             o_HeadX, o_HeadY, o_Dir, e.x, e.y, e.dir);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        Rst = 1'b1;
        chk("rst_x", int'(o_HeadX), 16);
        chk("rst_y", int'(o_HeadY), 12);
        chk("rst_dir", int'(o_Dir), 3);
        chk("rst_step", int'(o_Step), 0);
        chk("rst_dead", int'(o_Dead), 0);
        chk("rst_state", int'(o_State), 0);
        repeat (4) tick();
        chk("idle_hold", int'(o_State), 0);

        // Start moving right at the fastest speed.
        push(17, 12, 3);
        push(18, 12, 3);
        press(4'b0111);
        chk("run_state", int'(o_State), 1);
        chk("run_dir", int'(o_Dir), 3);
        wait_step("first_step_latency", 4);
        wait_step("period_p4", 4);

        // Left is a reversal and is dropped; up steers the step after next.
        push(19, 12, 3);
        push(19, 11, 0);
        press(4'b1011);
        chk("reject_dir", int'(o_Dir), 3);
        press(4'b1110);
        wait_step("turn_up_step", 2);

        // Pause with the timer at 2.
        tick();
        tick();
        i_Pause = 1'b1;
        tick();
        chk("pause_state", int'(o_State), 2);
        repeat (19) tick();
        chk("pause_hold_state", int'(o_State), 2);
        chk("pause_hold_x", int'(o_HeadX), 19);
        chk("pause_hold_y", int'(o_HeadY), 11);
        push(19, 10, 0);
        i_Pause = 1'b0;
        wait_step("resume_latency", 3);

        // Turn right towards the east wall, exercising speed changes on the way.
        for (int x = 20; x <= 31; x++) push(x, 10, 3);
        i_Speed = 3'd0;
        press(4'b0111);
        wait_step("turn_right_step", 1);
        wait_step("period_slow", 16);
        i_Speed = 3'd7;
        wait_step("period_slow_again", 16);
        wait_step("period_clamped", 4);
        for (int i = 0; i < 8; i++) wait_step("period_fast", 4);
        chk("at_east_edge", int'(o_HeadX), 31);

`ifdef SNAKE_WRAP_EN
        push(0, 10, 3);
        repeat (4) tick();
        chk("wrap_step", int'(o_Step), 1);
        chk("wrap_x", int'(o_HeadX), 0);
        chk("wrap_dead", int'(o_Dead), 0);
        chk("wrap_state", int'(o_State), 1);
`else
        repeat (4) tick();
        chk("wall_dead", int'(o_Dead), 1);
        chk("wall_x", int'(o_HeadX), 31);
        chk("wall_state", int'(o_State), 3);
        chk("wall_nostep", int'(o_Step), 0);
        repeat (5) tick();
        press(4'b1110);
        chk("dead_hold_state", int'(o_State), 3);
        chk("dead_hold_x", int'(o_HeadX), 31);
        chk("dead_hold_flag", int'(o_Dead), 1);
`endif

        i_Restart = 1'b1;
        tick();
        i_Restart = 1'b0;
        chk("restart_x", int'(o_HeadX), 16);
        chk("restart_y", int'(o_HeadY), 12);
        chk("restart_dir", int'(o_Dir), 3);
        chk("restart_dead", int'(o_Dead), 0);
        chk("restart_state", int'(o_State), 0);

        // Up and down pressed together: up has priority; IDLE applies no filter.
        push(16, 11, 0);
        press(4'b1100);
        chk("prio_dir", int'(o_Dir), 0);
        wait_step("prio_step", 4);

        // Asynchronous reset mid-period, checked before the next clock edge.
        tick();
        tick();
        Rst = 1'b0;
        #2;
        chk("arst_x", int'(o_HeadX), 16);
        chk("arst_y", int'(o_HeadY), 12);
        chk("arst_dir", int'(o_Dir), 3);
        chk("arst_state", int'(o_State), 0);
        tick();
        Rst = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", int'(o_State), 0);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
